// File: rtl/qcw_burst_sequencer.sv
// qcw_burst_sequencer: one trigger launches one QCW burst. The block pulses
// the PLL start, programs its cycle limit, ramps the phase-shift word every N
// drive cycles, enforces a cooldown between bursts, and locks out on PLL or
// watchdog faults until the fault is cleared with the block disarmed.
module qcw_burst_sequencer #(
   parameter int unsigned HOLDOFF_CLKS  = 1000000,
   parameter int unsigned WATCHDOG_CLKS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        trigger,
   input  logic        fault_clear,
   input  logic [7:0]  phase_start,
   input  logic [7:0]  phase_end,
   input  logic [7:0]  phase_step,
   input  logic [7:0]  step_interval,
   input  logic [15:0] burst_cycles,
   output logic        pll_start,
   output logic        pll_halt,
   output logic [7:0]  phase_shift,
   output logic [15:0] cycle_limit,
   input  logic        pll_cycle_finished,
   input  logic        pll_done,
   input  logic        pll_fault,
   output logic        busy,
   output logic        fault_latched,
   output logic        aborted,
   output logic [15:0] burst_count
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_HALTING  = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   // Cooldown counts down from HOLDOFF_CLKS-1 to 0, so it lasts HOLDOFF_CLKS clocks.
   localparam logic [23:0] HOLDOFF_LOAD = 24'(HOLDOFF_CLKS - 1);
   // Watchdog trips when the counter reaches its last legal value.
   localparam logic [15:0] WD_LAST      = 16'(WATCHDOG_CLKS - 1);

   state_t      state_q, state_d;

   // Edge-detect history
   logic        trigger_q, trigger_d;
   logic        cf_q, cf_d;
   logic        done_q, done_d;
   logic        fault_q, fault_d;

   // Registered outputs
   logic        pll_start_q, pll_start_d;
   logic        pll_halt_q, pll_halt_d;
   logic [7:0]  phase_shift_q, phase_shift_d;
   logic [15:0] cycle_limit_q, cycle_limit_d;
   logic        fault_latched_q, fault_latched_d;
   logic        aborted_q, aborted_d;
   logic [15:0] burst_count_q, burst_count_d;

   // Ramp parameters captured at launch so mid-burst input changes are harmless
   logic [7:0]  phase_end_q, phase_end_d;
   logic [7:0]  phase_step_q, phase_step_d;
   logic [7:0]  step_interval_q, step_interval_d;

   // Counters
   logic [7:0]  step_cnt_q, step_cnt_d;
   logic [15:0] wd_cnt_q, wd_cnt_d;
   logic [23:0] hold_cnt_q, hold_cnt_d;

   logic        trigger_rise;
   logic        cf_rise;
   logic        done_rise;
   logic        fault_rise;
   logic        launch_ok;

   logic [8:0]  ramp_sum;
   logic [7:0]  ramp_next;
   logic [7:0]  step_last;

   assign trigger_rise = trigger & ~trigger_q;
   assign cf_rise      = pll_cycle_finished & ~cf_q;
   assign done_rise    = pll_done & ~done_q;
   assign fault_rise   = pll_fault & ~fault_q;
   assign launch_ok    = trigger_rise & enable & (burst_cycles != 16'd0);

   // Next ramp value: 9-bit sum so it never wraps, clamped to the ceiling,
   // and frozen if the start already sits at or above the ceiling.
   always_comb begin
      ramp_sum  = {1'b0, phase_shift_q} + {1'b0, phase_step_q};
      ramp_next = phase_shift_q;
      if (phase_shift_q >= phase_end_q) begin
         ramp_next = phase_shift_q;
      end else if (ramp_sum > {1'b0, phase_end_q}) begin
         ramp_next = phase_end_q;
      end else begin
         ramp_next = ramp_sum[7:0];
      end
      step_last = (step_interval_q == 8'd0) ? 8'd0 : step_interval_q - 8'd1;
   end

   // Next-state and output logic for the burst sequencer
   always_comb begin
      state_d         = state_q;
      trigger_d       = trigger;
      cf_d            = pll_cycle_finished;
      done_d          = pll_done;
      fault_d         = pll_fault;
      pll_start_d     = 1'b0;
      pll_halt_d      = pll_halt_q;
      phase_shift_d   = phase_shift_q;
      cycle_limit_d   = cycle_limit_q;
      fault_latched_d = fault_latched_q;
      aborted_d       = aborted_q;
      burst_count_d   = burst_count_q;
      phase_end_d     = phase_end_q;
      phase_step_d    = phase_step_q;
      step_interval_d = step_interval_q;
      step_cnt_d      = step_cnt_q;
      wd_cnt_d        = wd_cnt_q;
      hold_cnt_d      = hold_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (launch_ok) begin
               phase_end_d     = phase_end;
               phase_step_d    = phase_step;
               step_interval_d = step_interval;
               phase_shift_d   = phase_start;
               cycle_limit_d   = burst_cycles;
               aborted_d       = 1'b0;
               pll_start_d     = 1'b1;
               step_cnt_d      = 8'd0;
               wd_cnt_d        = 16'd0;
               state_d         = ST_RUN;
            end
         end

         ST_RUN: begin
            // Ramp and watchdog bookkeeping; exits below may override it.
            if (cf_rise) begin
               wd_cnt_d = 16'd0;
               if (step_cnt_q == step_last) begin
                  step_cnt_d    = 8'd0;
                  phase_shift_d = ramp_next;
               end else begin
                  step_cnt_d = step_cnt_q + 8'd1;
               end
            end else begin
               wd_cnt_d = wd_cnt_q + 16'd1;
            end

            if (fault_rise) begin
               fault_latched_d = 1'b1;
               phase_shift_d   = 8'd0;
               state_d         = ST_FAULT;
            end else if (wd_cnt_q == WD_LAST) begin
               fault_latched_d = 1'b1;
               pll_halt_d      = 1'b1;
               phase_shift_d   = 8'd0;
               state_d         = ST_FAULT;
            end else if (done_rise) begin
               // A coincident ramp step is discarded: cooldown zeroes the phase.
               burst_count_d = burst_count_q + 16'd1;
               phase_shift_d = 8'd0;
               hold_cnt_d    = HOLDOFF_LOAD;
               state_d       = ST_COOLDOWN;
            end else if (!enable) begin
               pll_halt_d = 1'b1;
               wd_cnt_d   = 16'd0;
               state_d    = ST_HALTING;
            end
         end

         ST_HALTING: begin
            // Either PLL edge means it has stopped; a fault here is our own doing.
            if (fault_rise || done_rise) begin
               pll_halt_d    = 1'b0;
               aborted_d     = 1'b1;
               phase_shift_d = 8'd0;
               hold_cnt_d    = HOLDOFF_LOAD;
               state_d       = ST_COOLDOWN;
            end else if (wd_cnt_q == WD_LAST) begin
               fault_latched_d = 1'b1;
               phase_shift_d   = 8'd0;
               state_d         = ST_FAULT;
            end else begin
               wd_cnt_d = wd_cnt_q + 16'd1;
            end
         end

         ST_COOLDOWN: begin
            if (hold_cnt_q == 24'd0) begin
               state_d = ST_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - 24'd1;
            end
         end

         ST_FAULT: begin
            // Lockout is released only while disarmed.
            if (fault_clear && !enable) begin
               fault_latched_d = 1'b0;
               pll_halt_d      = 1'b0;
               hold_cnt_d      = HOLDOFF_LOAD;
               state_d         = ST_COOLDOWN;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         trigger_q       <= 1'b0;
         cf_q            <= 1'b0;
         done_q          <= 1'b0;
         fault_q         <= 1'b0;
         pll_start_q     <= 1'b0;
         pll_halt_q      <= 1'b0;
         phase_shift_q   <= 8'd0;
         cycle_limit_q   <= 16'd0;
         fault_latched_q <= 1'b0;
         aborted_q       <= 1'b0;
         burst_count_q   <= 16'd0;
         phase_end_q     <= 8'd0;
         phase_step_q    <= 8'd0;
         step_interval_q <= 8'd0;
         step_cnt_q      <= 8'd0;
         wd_cnt_q        <= 16'd0;
         hold_cnt_q      <= 24'd0;
      end else begin
         state_q         <= state_d;
         trigger_q       <= trigger_d;
         cf_q            <= cf_d;
         done_q          <= done_d;
         fault_q         <= fault_d;
         pll_start_q     <= pll_start_d;
         pll_halt_q      <= pll_halt_d;
         phase_shift_q   <= phase_shift_d;
         cycle_limit_q   <= cycle_limit_d;
         fault_latched_q <= fault_latched_d;
         aborted_q       <= aborted_d;
         burst_count_q   <= burst_count_d;
         phase_end_q     <= phase_end_d;
         phase_step_q    <= phase_step_d;
         step_interval_q <= step_interval_d;
         step_cnt_q      <= step_cnt_d;
         wd_cnt_q        <= wd_cnt_d;
         hold_cnt_q      <= hold_cnt_d;
      end
   end

   assign pll_start     = pll_start_q;
   assign pll_halt      = pll_halt_q;
   assign phase_shift   = phase_shift_q;
   assign cycle_limit   = cycle_limit_q;
   assign fault_latched = fault_latched_q;
   assign aborted       = aborted_q;
   assign burst_count   = burst_count_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qcw_burst_sequencer.sv
// Testbench for qcw_burst_sequencer: directed scenarios plus a random soak,
// all checked every cycle against a burst-level behavioural model.
module tb_qcw_burst_sequencer;

   localparam int HOLD = 16;
   localparam int WD   = 40;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;
   localparam int M_COOL = 3;
   localparam int M_FLT  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        trigger = 1'b0;
   logic        fault_clear = 1'b0;
   logic [7:0]  phase_start = 8'd0;
   logic [7:0]  phase_end = 8'd0;
   logic [7:0]  phase_step = 8'd0;
   logic [7:0]  step_interval = 8'd0;
   logic [15:0] burst_cycles = 16'd0;
   logic        pll_cycle_finished = 1'b0;
   logic        pll_done = 1'b0;
   logic        pll_fault = 1'b0;
   logic        pll_start;
   logic        pll_halt;
   logic [7:0]  phase_shift;
   logic [15:0] cycle_limit;
   logic        busy;
   logic        fault_latched;
   logic        aborted;
   logic [15:0] burst_count;

   qcw_burst_sequencer #(
      .HOLDOFF_CLKS (HOLD),
      .WATCHDOG_CLKS(WD)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .enable            (enable),
      .trigger           (trigger),
      .fault_clear       (fault_clear),
      .phase_start       (phase_start),
      .phase_end         (phase_end),
      .phase_step        (phase_step),
      .step_interval     (step_interval),
      .burst_cycles      (burst_cycles),
      .pll_start         (pll_start),
      .pll_halt          (pll_halt),
      .phase_shift       (phase_shift),
      .cycle_limit       (cycle_limit),
      .pll_cycle_finished(pll_cycle_finished),
      .pll_done          (pll_done),
      .pll_fault         (pll_fault),
      .busy              (busy),
      .fault_latched     (fault_latched),
      .aborted           (aborted),
      .burst_count       (burst_count)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   int   cyc = 0;
   int   m_mode;
   logic m_start, m_halt, m_lat, m_ab;
   int   m_phase, m_cl, m_bc;
   int   p_start, p_end, p_step, p_int;
   int   cf_seen;      // cycle_finished rises seen in this burst
   int   ref_cyc;      // clock of the last watchdog restart
   int   cd_until;     // clock at which cooldown returns to idle
   logic h_tr, h_cf, h_dn, h_ft;

   // Phase depends only on how many complete steps have occurred.
   function automatic int ramp_value();
      int k;
      k = cf_seen / ((p_int == 0) ? 1 : p_int);
      if (p_start >= p_end) return p_start;
      if (p_start + k * p_step > p_end) return p_end;
      return p_start + k * p_step;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_start = 0; m_halt = 0; m_lat = 0; m_ab = 0;
      m_phase = 0; m_cl = 0; m_bc = 0;
      p_start = 0; p_end = 0; p_step = 0; p_int = 0;
      cf_seen = 0; ref_cyc = 0; cd_until = 0;
      h_tr = 0; h_cf = 0; h_dn = 0; h_ft = 0;
   endtask

   task automatic enter_cool();
      m_mode = M_COOL; m_phase = 0; cd_until = cyc + HOLD;
   endtask

   task automatic model_step();
      logic tr, cr, dr, fr;
      tr = trigger & ~h_tr;
      cr = pll_cycle_finished & ~h_cf;
      dr = pll_done & ~h_dn;
      fr = pll_fault & ~h_ft;
      h_tr = trigger; h_cf = pll_cycle_finished; h_dn = pll_done; h_ft = pll_fault;
      m_start = 0;
      case (m_mode)
         M_IDLE: if (tr && enable && burst_cycles != 0) begin
            p_start = phase_start; p_end = phase_end; p_step = phase_step; p_int = step_interval;
            m_cl = burst_cycles; m_ab = 0; m_start = 1; cf_seen = 0; ref_cyc = cyc;
            m_phase = p_start; m_mode = M_RUN;
         end
         M_RUN: begin
            if (fr) begin
               m_mode = M_FLT; m_lat = 1; m_phase = 0;
            end else if (cyc - ref_cyc == WD) begin
               m_mode = M_FLT; m_lat = 1; m_halt = 1; m_phase = 0;
            end else if (dr) begin
               m_bc = (m_bc + 1) % 65536; enter_cool();
            end else begin
               if (cr) begin cf_seen++; ref_cyc = cyc; end
               m_phase = ramp_value();
               if (!enable) begin m_mode = M_HALT; m_halt = 1; ref_cyc = cyc; end
            end
         end
         M_HALT: begin
            if (fr || dr) begin
               m_halt = 0; m_ab = 1; enter_cool();
            end else if (cyc - ref_cyc == WD) begin
               m_mode = M_FLT; m_lat = 1; m_phase = 0;
            end
         end
         M_COOL: if (cyc >= cd_until) m_mode = M_IDLE;
         M_FLT: if (fault_clear && !enable) begin
            m_lat = 0; m_halt = 0; enter_cool();
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         cyc++;
         if (rst) model_reset();
         else model_step();
      end
   end

   // Every-cycle comparison of all outputs against the model.
   // Layout: {start,halt,phase[8],limit[16],busy,fault,aborted,count[16]}
   initial forever begin
      logic [44:0] act_v, exp_v;
      @(negedge clk);
      act_v = {pll_start, pll_halt, phase_shift, cycle_limit, busy, fault_latched, aborted, burst_count};
      exp_v = {m_start, m_halt, 8'(m_phase), 16'(m_cl), (m_mode != M_IDLE), m_lat, m_ab, 16'(m_bc)};
      chk($sformatf("outputs cyc%0d", cyc), 64'(act_v), 64'(exp_v));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic launch();
      trigger = 1'b1;
      tick(1);
      trigger = 1'b0;
   endtask

   task automatic cf_pulse();
      pll_cycle_finished = 1'b1;
      tick(1);
      pll_cycle_finished = 1'b0;
      tick(1);
   endtask

   task automatic set_params(input int s, input int e, input int st, input int iv, input int bc);
      phase_start = 8'(s); phase_end = 8'(e); phase_step = 8'(st);
      step_interval = 8'(iv); burst_cycles = 16'(bc);
   endtask

   int ramp_exp [6] = '{20, 30, 40, 50, 50, 50};

   initial begin
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset burst_count", 64'(burst_count), 64'd0);
      chk("reset phase_shift", 64'(phase_shift), 64'd0);

      // Basic burst
      enable = 1'b1;
      set_params(10, 50, 10, 2, 12);
      launch();
      chk("basic pll_start", 64'(pll_start), 64'd1);
      chk("basic cycle_limit", 64'(cycle_limit), 64'd12);
      chk("basic first phase", 64'(phase_shift), 64'd10);
      tick(1);
      chk("basic start one clock", 64'(pll_start), 64'd0);
      for (int i = 1; i <= 12; i++) begin
         cf_pulse();
         if (i % 2 == 0) chk($sformatf("basic ramp %0d", i), 64'(phase_shift), 64'(ramp_exp[i/2-1]));
      end
      pll_done = 1'b1;
      tick(1);
      chk("basic burst_count", 64'(burst_count), 64'd1);
      chk("basic cooldown phase", 64'(phase_shift), 64'd0);
      trigger = 1'b1;
      tick(1);
      trigger = 1'b0;
      chk("cooldown trigger dropped", 64'(pll_start), 64'd0);
      tick(HOLD - 3);
      chk("cooldown still busy", 64'(busy), 64'd1);
      tick(2);
      chk("cooldown done", 64'(busy), 64'd0);
      pll_done = 1'b0;
      $display("transaction basic burst: count=%0d", burst_count);

      // Saturation without wrap
      set_params(250, 255, 20, 0, 5);
      tick(1);
      launch();
      chk("sat start phase", 64'(phase_shift), 64'd250);
      cf_pulse();
      chk("sat clamp", 64'(phase_shift), 64'd255);
      cf_pulse();
      chk("sat hold", 64'(phase_shift), 64'd255);
      pll_done = 1'b1; tick(1); pll_done = 1'b0;
      tick(HOLD + 1);
      set_params(100, 5, 7, 1, 5);
      launch();
      repeat (3) cf_pulse();
      chk("inverted range hold", 64'(phase_shift), 64'd100);
      pll_done = 1'b1; tick(1); pll_done = 1'b0;
      tick(HOLD + 1);
      $display("transaction saturation bursts: count=%0d", burst_count);

      // Abort
      set_params(10, 50, 10, 2, 12);
      launch();
      repeat (5) cf_pulse();
      enable = 1'b0;
      tick(1);
      chk("abort halt", 64'(pll_halt), 64'd1);
      pll_fault = 1'b1;
      tick(1);
      chk("abort halt released", 64'(pll_halt), 64'd0);
      chk("abort flag", 64'(aborted), 64'd1);
      chk("abort no fault", 64'(fault_latched), 64'd0);
      chk("abort count kept", 64'(burst_count), 64'd3);
      pll_fault = 1'b0; enable = 1'b1;
      tick(HOLD + 1);
      $display("transaction abort: aborted=%0d", aborted);

      // PLL fault and lockout
      launch();
      tick(2);
      pll_fault = 1'b1;
      tick(1);
      chk("fault latched", 64'(fault_latched), 64'd1);
      pll_fault = 1'b0;
      launch();
      chk("fault trigger ignored", 64'(pll_start), 64'd0);
      fault_clear = 1'b1;
      tick(2);
      chk("fault clear ignored when armed", 64'(fault_latched), 64'd1);
      enable = 1'b0;
      tick(1);
      chk("fault cleared", 64'(fault_latched), 64'd0);
      fault_clear = 1'b0;
      tick(HOLD + 1);
      chk("fault back to idle", 64'(busy), 64'd0);
      enable = 1'b1;
      $display("transaction pll fault lockout done");

      // Run watchdog
      launch();
      tick(WD - 1);
      chk("watchdog not yet", 64'(fault_latched), 64'd0);
      tick(1);
      chk("watchdog fault", 64'(fault_latched), 64'd1);
      chk("watchdog halt", 64'(pll_halt), 64'd1);
      enable = 1'b0; fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
      tick(HOLD + 1);
      enable = 1'b1;
      $display("transaction run watchdog done");

      // Halting watchdog
      launch();
      enable = 1'b0;
      tick(1);
      chk("halting halt", 64'(pll_halt), 64'd1);
      tick(WD - 1);
      chk("halting not yet", 64'(fault_latched), 64'd0);
      tick(1);
      chk("halting timeout fault", 64'(fault_latched), 64'd1);
      fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
      tick(HOLD + 1);
      enable = 1'b1;
      $display("transaction halting watchdog done");

      // Trigger held high launches once
      trigger = 1'b1;
      tick(10);
      trigger = 1'b0;
      chk("held trigger busy", 64'(busy), 64'd1);
      pll_done = 1'b1; tick(1); pll_done = 1'b0;
      tick(HOLD + 1);
      $display("transaction held trigger: count=%0d", burst_count);

      // Asynchronous reset mid-run
      launch();
      repeat (3) cf_pulse();
      @(posedge clk); #1;
      rst = 1'b1;
      #2;
      chk("async reset outputs", 64'({pll_start, pll_halt, phase_shift, cycle_limit, busy,
                                      fault_latched, aborted, burst_count}), 64'd0);
      tick(2);
      rst = 1'b0;
      tick(1);
      chk("after reset idle", 64'(busy), 64'd0);
      $display("transaction async reset done");

      // Random soak
      for (int i = 0; i < 4000; i++) begin
         enable = ($urandom_range(0, 99) < 97);
         trigger = ($urandom_range(0, 3) == 0);
         pll_cycle_finished = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 99) < 4) pll_done = ~pll_done;
         if ($urandom_range(0, 199) < 3) pll_fault = ~pll_fault;
         fault_clear = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 19) == 0)
            set_params($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, 4), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 65535));
         tick(1);
      end
      enable = 1'b0; trigger = 1'b0; pll_cycle_finished = 1'b0;
      pll_done = 1'b0; pll_fault = 1'b0; fault_clear = 1'b0;
      tick(HOLD + 5);
      $display("transaction random soak: count=%0d", burst_count);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
